// File: rtl/input_cond_pkg.sv
// Shared definitions for the board input conditioning blocks:
// default clock/tick rates and a width helper usable in parameter expressions.
package input_cond_pkg;

  localparam int CLK_HZ_DEFAULT  = 50000000;
  localparam int TICK_HZ_DEFAULT = 1000;

  // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV clocks,
// shared by the slow-rate sampling blocks.
module tick_prescaler
  import input_cond_pkg::*;
#(
  parameter int DIV = CLK_HZ_DEFAULT / TICK_HZ_DEFAULT
) (
  input  logic clk_clk,
  input  logic reset_reset,
  output logic tick
);

  localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("tick_prescaler: DIV must be at least 2");
  end

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + 1'b1;
    if (count_q == LAST) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button / switch conditioner: synchronise, normalise polarity,
// debounce on a slow tick, and flag level changes with one-cycle pulses.
module button_debouncer
  import input_cond_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLK_HZ       = CLK_HZ_DEFAULT,
  parameter int TICK_HZ      = TICK_HZ_DEFAULT,
  parameter int STABLE_TICKS = 20,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = (clog2(STABLE_TICKS + 1) < 1) ? 1 : clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [WIDTH-1:0] IDLE_RAW = {WIDTH{ACTIVE_LOW}};

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2 || STABLE_TICKS < 1) begin : g_bad_params
    $error("button_debouncer: CLK_HZ must be a multiple of TICK_HZ, DIV >= 2, STABLE_TICKS >= 1");
  end

  logic             tick;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] sampled;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             any_q, any_d;

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .tick       (tick)
  );

  // Synchroniser resets to the idle pin level so release from reset looks like "not pressed".
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1_q <= IDLE_RAW;
      sync2_q <= IDLE_RAW;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign sampled = sync2_q ^ IDLE_RAW;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_d, rise_c, fall_c;

    // A matching sample aborts verification; STABLE_TICKS mismatches in a row commit the new level.
    always_comb begin
      cnt_d  = cnt_q;
      lvl_d  = level_q[i];
      rise_c = 1'b0;
      fall_c = 1'b0;
      if (tick) begin
        if (sampled[i] == level_q[i]) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          cnt_d  = '0;
          lvl_d  = sampled[i];
          rise_c = sampled[i];
          fall_c = ~sampled[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign level_d[i] = lvl_d;
    assign rise_d[i]  = rise_c;
    assign fall_d[i]  = fall_c;
  end

  assign any_d = |(rise_d | fall_d);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_change = any_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with DIV=10, STABLE_TICKS=4, active-low pins.
module tb_button_debouncer;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic [3:0] raw_in;
  logic [3:0] level_out, rise_pulse, fall_pulse;
  logic       any_change;

  always #5 clk_clk = ~clk_clk;

  button_debouncer #(
    .WIDTH       (4),
    .CLK_HZ      (1000),
    .TICK_HZ     (100),
    .STABLE_TICKS(4),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .raw_in     (raw_in),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .any_change (any_change)
  );

  typedef struct {
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] level;
    int         lo;
    int         hi;
    string      name;
  } expT;

  expT        expQ[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [3:0] modelLevel = 4'h0;

  // Monitor: every output event must match the oldest expected event and land in its window.
  initial begin
    expT e;
    forever begin
      @(posedge clk_clk);
      cyc++;
      #1;
      if (any_change !== (|(rise_pulse | fall_pulse))) begin
        checks++;
        failures++;
        $display("[TB] FAIL anyChangeOr cyc=%0d any_change=%b rise=%b fall=%b", cyc, any_change, rise_pulse, fall_pulse);
      end
      if (any_change === 1'b1 || (rise_pulse | fall_pulse) !== 4'h0) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpectedEvent cyc=%0d rise=%b fall=%b level=%b required no event", cyc, rise_pulse, fall_pulse, level_out);
        end else begin
          e = expQ.pop_front();
          if (rise_pulse !== e.rise || fall_pulse !== e.fall || level_out !== e.level || cyc < e.lo || cyc > e.hi) begin
            failures++;
            $display("[TB] FAIL %s got rise=%b fall=%b level=%b cyc=%0d required rise=%b fall=%b level=%b cyc=%0d..%0d",
                     e.name, rise_pulse, fall_pulse, level_out, cyc, e.rise, e.fall, e.level, e.lo, e.hi);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [3:0] value);
    @(negedge clk_clk);
    raw_in = value;
  endtask

  task automatic pushEvent(input logic [3:0] rise, input logic [3:0] fall, input int lo, input int hi, input string name);
    expT e;
    modelLevel = (modelLevel | rise) & ~fall;
    e.rise  = rise;
    e.fall  = fall;
    e.level = modelLevel;
    e.lo    = lo;
    e.hi    = hi;
    e.name  = name;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic waitDrain(input string name, input int budget);
    for (int i = 0; i < budget && expQ.size() != 0; i++) begin
      @(negedge clk_clk);
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s timeout pending=%0d required=0", name, expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    reset_reset = 1'b1;
    raw_in      = 4'hF;
    repeat (3) @(negedge clk_clk);
    checkOutput("resetOutputs", {3'b0, level_out, rise_pulse, fall_pulse, any_change}, 16'h0000);
    reset_reset = 1'b0;

    // Idle: released buttons must never produce a level or pulse.
    repeat (200) @(negedge clk_clk);
    checkOutput("idleLevel", {12'h0, level_out}, {12'h0, modelLevel});

    applyStimulus(4'hE);
    pushEvent(4'h1, 4'h0, cyc + 33, cyc + 42, "press0Rise");
    waitDrain("press0Drain", 60);
    checkOutput("press0Level", {12'h0, level_out}, 16'h0001);

    applyStimulus(4'hF);
    pushEvent(4'h0, 4'h1, cyc + 33, cyc + 42, "release0Fall");
    waitDrain("release0Drain", 60);

    // Bounce on channel 1: toggles every 3 cycles, ending pressed.
    for (int i = 0; i < 25; i++) begin
      applyStimulus((((i / 3) % 2) == 0) ? 4'hD : 4'hF);
    end
    applyStimulus(4'hD);
    pushEvent(4'h2, 4'h0, cyc + 1, cyc + 42, "bounce1Rise");
    waitDrain("bounce1Drain", 60);
    checkOutput("bounce1Level", {12'h0, level_out}, 16'h0002);

    applyStimulus(4'hF);
    pushEvent(4'h0, 4'h2, cyc + 33, cyc + 42, "release1Fall");
    waitDrain("release1Drain", 60);

    // Single-cycle glitch on channel 2 must be ignored.
    repeat (7) @(negedge clk_clk);
    applyStimulus(4'hB);
    applyStimulus(4'hF);
    repeat (60) @(negedge clk_clk);
    checkOutput("glitch2Level", {12'h0, level_out}, 16'h0000);

    applyStimulus(4'h0);
    pushEvent(4'hF, 4'h0, cyc + 33, cyc + 42, "allRise");
    waitDrain("allRiseDrain", 60);
    checkOutput("allLevel", {12'h0, level_out}, 16'h000F);

    applyStimulus(4'hF);
    pushEvent(4'h0, 4'hF, cyc + 33, cyc + 42, "allFall");
    waitDrain("allFallDrain", 60);

    // Reset in the middle of verifying a press on channel 3.
    applyStimulus(4'h7);
    repeat (25) @(negedge clk_clk);
    reset_reset = 1'b1;
    #1;
    checkOutput("midResetEntry", {3'b0, level_out, rise_pulse, fall_pulse, any_change}, 16'h0000);
    repeat (3) begin
      @(negedge clk_clk);
      checkOutput("midResetHold", {3'b0, level_out, rise_pulse, fall_pulse, any_change}, 16'h0000);
    end
    reset_reset = 1'b0;
    pushEvent(4'h8, 4'h0, cyc + 33, cyc + 42, "postReset3Rise");
    waitDrain("postReset3Drain", 60);
    checkOutput("postReset3Level", {12'h0, level_out}, 16'h0008);

    applyStimulus(4'hF);
    pushEvent(4'h0, 4'h8, cyc + 33, cyc + 42, "release3Fall");
    waitDrain("release3Drain", 60);

    repeat (30) @(negedge clk_clk);
    checkOutput("finalLevel", {12'h0, level_out}, {12'h0, modelLevel});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions raw, bouncy board inputs (DE1-SoC KEY push-buttons; a second instance serves the slide switches) before they enter the HPS system's button PIO input.
- Per channel: 2-FF synchroniser, optional polarity inversion, tick-sampled debounce, one-cycle rise/fall event pulses.
- level_out connects directly to the PIO export input, so software sees clean, active-high, glitch-free levels.

Parameters:
- WIDTH, 4, number of independent channels.
- CLK_HZ, 50000000, clk_clk frequency in Hz.
- TICK_HZ, 1000, debounce sample rate in Hz; DIV = CLK_HZ/TICK_HZ.
- STABLE_TICKS, 20, consecutive mismatching samples required before a level flips.
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; the input is inverted after synchronisation.

Ports:
- clk_clk  in  1  system clock; same clock as the PIO fabric side.
- reset_reset  in  1  asynchronous, active-high reset.
- raw_in  in  WIDTH  asynchronous board pins.
- level_out  out  WIDTH  debounced logical level; 1 = pressed/on; drives button_pio_export.
- rise_pulse  out  WIDTH  one-cycle pulse when level_out bit goes 0->1.
- fall_pulse  out  WIDTH  one-cycle pulse when level_out bit goes 1->0.
- any_change  out  1  registered OR of all rise_pulse and fall_pulse bits, same cycle.

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is asynchronous and active-high on reset_reset; all registers clear asynchronously and release on the next clk_clk edge.
- Reset values:
  - level_out = 0; rise_pulse = 0; fall_pulse = 0; any_change = 0.
  - Prescaler = 0; all channel counters = 0.
  - Synchroniser flops = inactive raw level (all 1s when ACTIVE_LOW=1, else 0).
- Synchroniser: s = 2-FF sync of raw_in, then XOR with ACTIVE_LOW. Latency is 2 cycles.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - tick is high for exactly one cycle when count == DIV-1.
  - Free-running; never gated by channel activity.
- Per channel (independent): state is a counter cnt of width clog2(STABLE_TICKS+1). Implicit states are STABLE (cnt==0) and VERIFY (cnt>0).
  - Non-tick cycle: no change.
  - Tick with s == level_out: cnt <- 0. A bounce back aborts verification.
  - Tick with s != level_out and cnt < STABLE_TICKS-1: cnt <- cnt+1.
  - Tick with s != level_out and cnt == STABLE_TICKS-1: level_out <- s, cnt <- 0, and the matching rise/fall pulse is asserted in the same registered cycle as the level change.
- Pulses and any_change last exactly one cycle, then return to 0.
- Latency: from a raw edge to level_out, 2 + (STABLE_TICKS-1)*DIV + 1..DIV cycles.
- Boundary conditions:
  - Channels never interact; several bits may pulse in the same cycle.
  - A glitch shorter than DIV cycles that misses a tick has no effect.
  - Reset asserted mid-VERIFY clears the state; no pulse is emitted on reset entry or exit.
  - STABLE_TICKS = 1: the level flips on the first mismatching tick.
  - Elaboration error if CLK_HZ % TICK_HZ != 0, DIV < 2, or STABLE_TICKS < 1.

Decomposition:
- Shared package input_cond_pkg holds:
  - a clog2 helper function;
  - default constants CLK_HZ_DEFAULT = 50000000 and TICK_HZ_DEFAULT = 1000.
- Sub-module tick_prescaler (parameter DIV; ports clk_clk, reset_reset, tick) is reused by other slow-rate blocks.
- The per-channel logic is a generate loop in the top module, not a separate sub-module.

Test Plan:
Bench configuration: CLK_HZ=1000, TICK_HZ=100 (DIV=10), STABLE_TICKS=4, WIDTH=4, ACTIVE_LOW=1.
- Reset then idle: raw_in=4'hF for 200 cycles -> level_out=0, no pulses; all outputs 0 during reset.
- Clean press: raw_in[0] 1->0 and held -> level_out[0] rises 33..42 cycles after the edge; rise_pulse[0] is high exactly 1 cycle, coincident with any_change=1. Release -> fall_pulse[0] 1 cycle within 33..42 cycles.
- Bounce: raw_in[1] toggles every 3 cycles for 25 cycles, then settles low -> no pulse during the bounce; exactly one rise_pulse[1] within 42 cycles after settling.
- Short glitch: raw_in[2] low for 1 cycle between ticks -> level_out[2] unchanged, no pulses ever.
- Simultaneous: raw_in 4'hF -> 4'h0 in one cycle -> rise_pulse = 4'hF in a single cycle, level_out = 4'hF.
- Reset mid-verify: press raw_in[3], assert reset_reset after 25 cycles for 3 cycles, keep pressed -> outputs 0 during reset; rise_pulse[3] only 33..42 cycles after reset release.
